uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver presents with its one-cycle done pulse and stores it in a first-word-fall-through FIFO. It delivers bytes to the consumer over a valid/ready handshake. It also tracks fill level, an almost-full warning, and overflow (dropped bytes), so the slower consumer logic never has to meet the receiver's single-cycle strobe.

## Interface
- DEPTH, 16: number of byte entries; power of two, minimum 2.
- AF_LEVEL, 12: `almost_full` asserts when `count >= AF_LEVEL`; range 1..DEPTH.
- clk  input  1  system clock; same clock as the receiver.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  byte from the receiver; sampled only when `in_valid = 1`.
- in_valid  input  1  single-cycle write strobe (the receiver's done pulse); no backpressure.
- out_data  output  8  head-of-FIFO byte; equals `mem[rd_ptr]`.
- out_valid  output  1  high whenever the FIFO is non-empty.
- out_ready  input  1  consumer accepts the head byte when `out_valid & out_ready`.
- count  output  $clog2(DEPTH)+1  current number of stored bytes, 0..DEPTH.
- almost_full  output  1  registered, equals `count >= AF_LEVEL`.
- overflow  output  1  sticky flag; set when a byte is dropped.
- overflow_clr  input  1  clears `overflow` and `drop_count`.
- drop_count  output  8  number of dropped bytes; saturates at 255.

## Operation
- Storage: array `mem[DEPTH]` of 8 bits, `wr_ptr` and `rd_ptr` of `$clog2(DEPTH)` bits. Both pointers wrap naturally modulo DEPTH. `count` is held in its own register.
- push = `in_valid & (count < DEPTH | pop)`; pop = `out_valid & out_ready`.
- On push: `mem[wr_ptr] <= in_data` and `wr_ptr` increments.
- On pop: `rd_ptr` increments.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: the push is accepted, `count` stays DEPTH, and nothing is dropped.
- Empty with `in_valid`: only a write occurs. There is no bypass, because `out_valid` is 0 that cycle.
- Drop: occurs when `in_valid & count == DEPTH & !pop`. The byte is discarded, `overflow <= 1`, and `drop_count` increments, saturating at 255.
- `overflow_clr` and a drop in the same cycle: the clear wins, giving `overflow = 0` and `drop_count = 0`.
- `out_ready` while empty has no effect. The pointers never underflow.
- There is no FSM beyond the count and pointers. The block is fully determined by push, pop, and drop.

## Timing
- Reset values: `wr_ptr`, `rd_ptr`, `count` = 0; `out_valid` = 0; `almost_full` = 0; `overflow` = 0; `drop_count` = 0; all `mem` entries = 0, so `out_data` = 0.
- A reset asserted mid-operation discards all contents immediately, because the reset is asynchronous.
- Write-to-read latency is 1 cycle. A byte strobed in cycle N appears on `out_data` with `out_valid = 1` in cycle N+1.
- `out_data` and `out_valid` derive combinationally from registered state only. There is no combinational path from `out_ready` to any output.
- After a pop in cycle N, the next byte (if any) is presented in cycle N+1.
- `count`, `almost_full`, `overflow`, and `drop_count` all reflect the events of cycle N in cycle N+1.
- Sustained throughput is one byte per cycle in and out. This far exceeds the UART rate of 1 byte per 10×CLK_PER_BIT cycles.

## Structure
- No shared package is needed. Pointer and count widths are derived locally from DEPTH via `$clog2`.
- A single module with inline storage is sufficient.
- If the storage is later moved to block RAM, isolate it as the sub-module `uart_fifo_mem`: synchronous write and asynchronous read, DEPTH×8 bits.

## Test plan
- Reset, then strobe 0x55 for one cycle. Next cycle: `out_valid = 1`, `out_data = 0x55`, `count = 1`. Pulse `out_ready`. Next cycle: `out_valid = 0`, `count = 0`.
- Write 0x01..0x10 (16 bytes) with `out_ready = 0`. Then `count = 16` and `almost_full = 1` from the 12th byte onward. Drain with `out_ready = 1`: bytes emerge in order 0x01..0x10 across 16 consecutive cycles.
- Fill the FIFO to 16, then strobe 0xAA three times with `out_ready = 0`. Then `overflow = 1`, `drop_count = 3`, `count = 16`, and the head is still 0x01. Pulse `overflow_clr`: both clear.
- With the FIFO full, strobe 0xBB and hold `out_ready = 1` in the same cycle. No drop occurs, `count` stays 16, and 0xBB is the last byte read out.
- Push 40 bytes while popping continuously so that `wr_ptr` wraps twice. Data order is preserved and `count` never exceeds 1.
- With 5 bytes stored, assert `rst` mid-cycle. All outputs return immediately to their reset values. After reset is released, the first new byte is the first one read out.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and helpers for the UART receive byte buffer.
package uart_rx_fifo_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam logic [7:0]  DROP_MAX = 8'hFF;

  // Encoded as {push, pop} so the operation can be cast directly from the strobes.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH byte storage: synchronous write, asynchronous read, cleared on reset.
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer: captures receiver done pulses, hands bytes
// to the consumer over valid/ready, and tracks fill level and dropped bytes.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [7:0]             drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;

  logic     push, pop, full, drop;
  fifo_op_e op;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = out_valid & out_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;
  assign op        = fifo_op_e'({push, pop});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    af_d = (count_d >= AF_CNT);

    if (overflow_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d  = 1'b1;
      drop_d = sat_inc8(drop_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

  assign count       = count_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue scoreboard plus a table of directed vectors.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       almost_full;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic [7:0] drop_count;

  uart_rx_fifo #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb [$];
  bit         m_ovf  = 1'b0;
  int         m_drop = 0;

  typedef struct {
    bit         iv;
    logic [7:0] d;
    bit         rdy;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [4:0] exp_c;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid", 32'(out_valid), 32'(sb.size() > 0));
    chk("count", 32'(count), 32'(sb.size()));
    chk("almost_full", 32'(almost_full), 32'(sb.size() >= AF));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    if (sb.size() > 0) chk("head", 32'(out_data), 32'(sb[0]));
  endtask

  // One clock cycle: check state at negedge, drive inputs, advance model, wait posedge.
  task automatic cycle(input bit iv, input logic [7:0] d, input bit rdy, input bit clr);
    bit         p, full;
    logic [7:0] e;
    @(negedge clk);
    check_model();
    in_valid     = iv;
    in_data      = d;
    out_ready    = rdy;
    overflow_clr = clr;
    full = (sb.size() == DEPTH);
    p    = rdy && (sb.size() > 0);
    if (p) begin
      e = sb.pop_front();
      chk("pop_data", 32'(out_data), 32'(e));
    end
    if (iv && (!full || p)) sb.push_back(d);
    if (iv && full && !p) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(posedge clk);
  endtask

  initial begin
    tbl[0] = '{iv: 1, d: 8'h55, rdy: 0, exp_v: 1, exp_d: 8'h55, exp_c: 5'd1};
    tbl[1] = '{iv: 0, d: 8'h00, rdy: 1, exp_v: 0, exp_d: 8'h00, exp_c: 5'd0};
    tbl[2] = '{iv: 1, d: 8'h5A, rdy: 1, exp_v: 1, exp_d: 8'h5A, exp_c: 5'd1};
    tbl[3] = '{iv: 1, d: 8'h3C, rdy: 1, exp_v: 1, exp_d: 8'h3C, exp_c: 5'd1};
    tbl[4] = '{iv: 0, d: 8'h00, rdy: 0, exp_v: 1, exp_d: 8'h3C, exp_c: 5'd1};
    tbl[5] = '{iv: 0, d: 8'h00, rdy: 1, exp_v: 0, exp_d: 8'h00, exp_c: 5'd0};

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].iv, tbl[i].d, tbl[i].rdy, 1'b0);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_c));
    end

    // Fill 0x01..0x10 with the consumer stalled.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    #1;
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_af", 32'(almost_full), 32'd1);

    // Three drops while full.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    #1;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd3);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_head", 32'(out_data), 32'h01);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drops", 32'(drop_count), 32'd0);

    // Full with simultaneous pop: push accepted, no drop.
    cycle(1'b1, 8'hBB, 1'b1, 1'b0);
    #1;
    chk("fullpop_count", 32'(count), 32'd16);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Drop counter saturation, then clear colliding with a drop.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    #1;
    chk("sat_drops", 32'(drop_count), 32'd255);
    cycle(1'b1, 8'hCC, 1'b0, 1'b1);
    #1;
    chk("clrwin_ovf", 32'(overflow), 32'd0);
    chk("clrwin_drops", 32'(drop_count), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Streaming: push and pop every cycle so the pointers wrap.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      #1;
      chk("stream_count_le1", 32'(count <= 5'd1), 32'd1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset with 5 bytes stored.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_af", 32'(almost_full), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_drop", 32'(drop_count), 32'd0);
    sb.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'h88, 1'b0, 1'b0);
    #1;
    chk("post_rst_head", 32'(out_data), 32'h77);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
